// File: rtl/shifter_set_monitor_if.sv
// Bus bundle for shifter_set_monitor: run control, chain stimulus/response
// and the indexed counter readout port.
interface shifter_set_monitor_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              EN;
  logic [1:0]        MODE;
  logic              CLR;
  logic [NUM_CH-1:0] SHIFT_OUT;
  logic [NUM_CH-1:0] SHIFT_IN;
  logic [SEL_W-1:0]  RD_SEL;
  logic [CNT_W-1:0]  RD_DATA;
  logic              RD_OVF;
  logic              ANY_ERR;

  modport master (
    output EN, MODE, CLR, SHIFT_OUT, RD_SEL,
    input  SHIFT_IN, RD_DATA, RD_OVF, ANY_ERR
  );

  modport slave (
    input  EN, MODE, CLR, SHIFT_OUT, RD_SEL,
    output SHIFT_IN, RD_DATA, RD_OVF, ANY_ERR
  );
endinterface

// File: rtl/shifter_set_monitor.sv
// Multi-channel SET monitor: drives a known pattern into NUM_CH shifter
// chains, compares synchronized chain outputs against a delayed copy of the
// pattern and counts mismatch events per channel in saturating counters.
module shifter_set_monitor #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LAT         = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  CLK,
  input logic                  RST,
  shifter_set_monitor_if.slave bus
);
  localparam int unsigned D     = LAT + SYNC_STAGES;
  localparam int unsigned BLK_W = $clog2(D + 1);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    MODE_ONES  = 2'd0,
    MODE_ZEROS = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  mode_e                          r_mode;
  logic                           r_pat;
  logic                           w_idle;
  logic [D-1:0]                   r_dly;
  logic                           w_exp;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
  logic [NUM_CH-1:0]              w_sync;
  logic [BLK_W-1:0]               r_blk;
  logic                           w_cmp_en;
  logic [NUM_CH-1:0]              r_mis;
  logic [NUM_CH-1:0]              r_mis_q;
  logic [NUM_CH-1:0]              w_evt;
  logic [NUM_CH-1:0][CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]              r_ovf;
  logic [CNT_W-1:0]               w_rd_data;
  logic                           w_rd_ovf;
  logic                           w_any;
  logic [CNT_W-1:0]               r_rd_data;
  logic                           r_rd_ovf;
  logic                           r_any;

  // Idle value of the incoming mode; it becomes the latched mode while EN=0,
  // so p already holds the right start value when EN rises.
  always_comb begin
    w_idle = (mode_e'(bus.MODE) == MODE_ZEROS) ? 1'b0 : 1'b1;
  end

  // Mode latch: only follows MODE while the run is stopped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_mode <= MODE_ONES;
    else if (!bus.EN) r_mode <= mode_e'(bus.MODE);
  end

  // Pattern generator bit p.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pat <= 1'b1;
    end else if (!bus.EN) begin
      r_pat <= w_idle;
    end else begin
      case (r_mode)
        MODE_ZEROS: r_pat <= 1'b0;
        MODE_ALT:   r_pat <= ~r_pat;
        default:    r_pat <= 1'b1;
      endcase
    end
  end

  assign bus.SHIFT_IN = {NUM_CH{r_pat}};

  // Expected-value delay line matching chain latency plus synchronizer depth.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_dly <= '1;
    else     r_dly <= {r_dly[D-2:0], r_pat};
  end

  assign w_exp = r_dly[D-1];

  // Synchronizer chain on the asynchronous chain outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.SHIFT_OUT};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Blanking counter; reloading while EN=0 also covers the EN rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                r_blk <= BLK_W'(D);
    else if (!bus.EN)       r_blk <= BLK_W'(D);
    else if (r_blk != '0)   r_blk <= r_blk - BLK_W'(1);
  end

  assign w_cmp_en = bus.EN & (r_blk == '0);

  // Registered mismatch flag and its previous value for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mis   <= '0;
      r_mis_q <= '0;
    end else if (bus.CLR) begin
      r_mis   <= '0;
      r_mis_q <= '0;
    end else begin
      r_mis   <= w_cmp_en ? (w_sync ^ {NUM_CH{w_exp}}) : '0;
      r_mis_q <= r_mis;
    end
  end

  assign w_evt = r_mis & ~r_mis_q;

  // Saturating per-channel event counters with sticky overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (bus.CLR) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_evt[i]) begin
          if (r_cnt[i] == '1) r_ovf[i] <= 1'b1;
          else                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Readout mux (out-of-range select yields zero) and any-error reduction.
  always_comb begin
    w_rd_data = '0;
    w_rd_ovf  = 1'b0;
    w_any     = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.RD_SEL == SEL_W'(i)) begin
        w_rd_data = r_cnt[i];
        w_rd_ovf  = r_ovf[i];
      end
      if (r_cnt[i] != '0) w_any = 1'b1;
    end
  end

  // Registered readout and status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_data <= '0;
      r_rd_ovf  <= 1'b0;
      r_any     <= 1'b0;
    end else begin
      r_rd_data <= w_rd_data;
      r_rd_ovf  <= w_rd_ovf;
      r_any     <= w_any;
    end
  end

  assign bus.RD_DATA = r_rd_data;
  assign bus.RD_OVF  = r_rd_ovf;
  assign bus.ANY_ERR = r_any;

endmodule

// File: tb/tb_shifter_set_monitor.sv
// Bench for shifter_set_monitor: chains modelled as a 3-cycle delay of
// SHIFT_IN with an XOR fault mask; readouts checked by a scoreboard monitor.
module tb_shifter_set_monitor;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  shifter_set_monitor_if #(.NUM_CH(2), .CNT_W(4)) bus ();

  shifter_set_monitor #(
    .NUM_CH(2), .CNT_W(4), .LAT(3), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Chain model: 3 flops per channel, fault mask XORed onto the output.
  logic [1:0] c1, c2, c3;
  logic [1:0] flip = 2'b00;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      c1 <= 2'b11; c2 <= 2'b11; c3 <= 2'b11;
    end else begin
      c1 <= bus.SHIFT_IN; c2 <= c1; c3 <= c2;
    end
  end
  assign bus.SHIFT_OUT = c3 ^ flip;

  typedef struct packed {
    logic [3:0] d;
    logic       ovf;
    logic       any;
  } exp_t;

  exp_t  sbq[$];
  string nmq[$];
  int    checks = 0;
  int    errors = 0;
  logic  rd_req = 1'b0;
  logic  rd_vld = 1'b0;

  always @(posedge CLK) rd_vld <= rd_req;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one readout presented per rd_vld, compared against the queue.
  initial begin
    forever begin
      @(negedge CLK);
      if (rd_vld) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got readout %0h with no expectation", bus.RD_DATA);
        end else begin
          exp_t  e;
          string n;
          e = sbq.pop_front();
          n = nmq.pop_front();
          chk({n, "_data"}, 16'(bus.RD_DATA), 16'(e.d));
          chk({n, "_ovf"},  16'(bus.RD_OVF),  16'(e.ovf));
          chk({n, "_any"},  16'(bus.ANY_ERR), 16'(e.any));
        end
      end
    end
  end

  task automatic rd(input logic sel, input logic [3:0] d, input logic ovf,
                    input logic any, input string nm);
    exp_t e;
    @(negedge CLK);
    bus.RD_SEL = sel;
    rd_req     = 1'b1;
    e.d = d; e.ovf = ovf; e.any = any;
    sbq.push_back(e);
    nmq.push_back(nm);
    @(negedge CLK);
    rd_req = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse(input int ch, input int len, input int gap);
    @(negedge CLK);
    flip[ch] = 1'b1;
    repeat (len) @(negedge CLK);
    flip[ch] = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic clr_pulse();
    @(negedge CLK);
    bus.CLR = 1'b1;
    @(negedge CLK);
    bus.CLR = 1'b0;
  endtask

  task automatic restart(input logic [1:0] mode);
    @(negedge CLK);
    bus.EN   = 1'b0;
    bus.MODE = mode;
    repeat (3) @(negedge CLK);
    bus.EN = 1'b1;
    repeat (12) @(negedge CLK);
  endtask

  // EN rises in cycle 0; chain output flipped in cycles f..l, which the
  // comparator sees two cycles later.
  task automatic en_rise(input int ch, input int f, input int l);
    for (int c = -2; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 0) bus.EN = 1'b1;
      flip[ch] = (c >= f && c <= l);
    end
    flip[ch] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.EN     = 1'b0;
    bus.MODE   = 2'd0;
    bus.CLR    = 1'b0;
    bus.RD_SEL = 1'b0;

    // Reset / idle
    repeat (2) @(negedge CLK);
    chk("rst_shift_in", 16'(bus.SHIFT_IN), 16'h3);
    chk("rst_rd_data",  16'(bus.RD_DATA),  16'h0);
    chk("rst_rd_ovf",   16'(bus.RD_OVF),   16'h0);
    chk("rst_any_err",  16'(bus.ANY_ERR),  16'h0);
    RST = 1'b0;
    rd(1'b0, 4'd0, 1'b0, 1'b0, "idle0");
    bus.EN = 1'b1;
    repeat (200) @(negedge CLK);
    rd(1'b0, 4'd0, 1'b0, 1'b0, "clean0");
    rd(1'b1, 4'd0, 1'b0, 1'b0, "clean1");

    // Mode 0 error run, then isolated pulses
    pulse(0, 5, 8);
    rd(1'b0, 4'd1, 1'b0, 1'b1, "run0");
    rd(1'b1, 4'd0, 1'b0, 1'b1, "run1");
    repeat (3) pulse(0, 1, 6);
    rd(1'b0, 4'd4, 1'b0, 1'b1, "pulses0");

    // Mode 2 alternating, single flipped bit on ch1
    clr_pulse();
    restart(2'd2);
    pulse(1, 1, 8);
    rd(1'b1, 4'd1, 1'b0, 1'b1, "alt1");
    rd(1'b0, 4'd0, 1'b0, 1'b1, "alt0");

    // Mode 1, ch0 stuck at 1 for many cycles counts once
    clr_pulse();
    restart(2'd1);
    pulse(0, 10, 8);
    rd(1'b0, 4'd1, 1'b0, 1'b1, "stuck0");

    // Saturation and clear
    clr_pulse();
    restart(2'd0);
    for (int i = 0; i < 20; i++) pulse(1, 1, 4);
    repeat (2) @(negedge CLK);
    rd(1'b1, 4'd15, 1'b1, 1'b1, "sat1");
    rd(1'b0, 4'd0,  1'b0, 1'b1, "sat0");
    clr_pulse();
    repeat (3) @(negedge CLK);
    rd(1'b1, 4'd0, 1'b0, 1'b0, "clr1");

    // CLR sampled on the same edge the event would be counted
    @(negedge CLK); flip[1] = 1'b1;
    @(negedge CLK); flip[1] = 1'b0;
    @(negedge CLK);
    @(negedge CLK); bus.CLR = 1'b1;
    @(negedge CLK); bus.CLR = 1'b0;
    repeat (6) @(negedge CLK);
    rd(1'b1, 4'd0, 1'b0, 1'b0, "clr_evt1");

    // Blanking: comparator cycles 0..4 ignored, cycle 5 counted
    @(negedge CLK); bus.EN = 1'b0;
    repeat (4) @(negedge CLK);
    en_rise(0, -2, 2);
    repeat (4) @(negedge CLK);
    rd(1'b0, 4'd0, 1'b0, 1'b0, "blank_early");
    @(negedge CLK); bus.EN = 1'b0;
    repeat (4) @(negedge CLK);
    en_rise(0, 3, 3);
    repeat (4) @(negedge CLK);
    rd(1'b0, 4'd1, 1'b0, 1'b1, "blank_edge");

    // MODE change while running does not alter the pattern
    @(negedge CLK); bus.MODE = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("mode_hold", 16'(bus.SHIFT_IN), 16'h3);
    end
    bus.MODE = 2'd0;
    repeat (8) @(negedge CLK);
    rd(1'b0, 4'd1, 1'b0, 1'b1, "mode_hold0");

    // RST mid-run
    repeat (6) pulse(0, 1, 5);
    rd(1'b0, 4'd7, 1'b0, 1'b1, "pre_rst0");
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_mid_rd_data", 16'(bus.RD_DATA), 16'h0);
    chk("rst_mid_any_err", 16'(bus.ANY_ERR), 16'h0);
    @(negedge CLK);
    RST = 1'b0;
    flip[0] = 1'b1;
    repeat (3) @(negedge CLK);
    flip[0] = 1'b0;
    repeat (8) @(negedge CLK);
    rd(1'b0, 4'd0, 1'b0, 1'b0, "post_rst_blank");
    pulse(0, 1, 6);
    rd(1'b0, 4'd1, 1'b0, 1'b1, "post_rst_live");

    // Drain scoreboard with a bound
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge CLK);
    chk("sb_drain", 16'(sbq.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shifter_set_monitor.md
# shifter_set_monitor

Multi-channel single-event-transient (SET) monitor for shift-register chains under radiation test. Drives a known stimulus pattern into NUM_CH shifter chains, compares each chain output against the expected value after the chain's pipeline latency, and counts error events per channel in saturating counters. A simple indexed read port exposes the counts. Sits in the FPGA test fabric between the DUT shifter pins and the host readout logic. Supersedes the fixed two-channel, hold-high, edge-clocked counter.

## Interface
Parameters:
- NUM_CH, 4, number of monitored shifter chains (1..16)
- CNT_W, 16, width of each error counter
- LAT, 8, DUT chain latency in CLK cycles, SHIFT_IN to SHIFT_OUT (≥1)
- SYNC_STAGES, 2, synchronizer flops on each SHIFT_OUT bit (≥2)

Ports:
- CLK  in  1  system clock; also clocks the DUT chains
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  run enable; compare active only while high
- MODE  in  2  0 = all-ones, 1 = all-zeros, 2 = alternating 1/0, 3 = reserved (behaves as 0)
- CLR  in  1  synchronous clear of all counters and overflow flags
- SHIFT_OUT  in  NUM_CH  DUT chain outputs, asynchronous
- SHIFT_IN  out  NUM_CH  stimulus to all chains; every bit carries the same pattern bit
- RD_SEL  in  max(1,clog2(NUM_CH))  channel select for readout
- RD_DATA  out  CNT_W  counter of selected channel, registered
- RD_OVF  out  1  overflow flag of selected channel, registered
- ANY_ERR  out  1  high while any channel counter is nonzero

## Operation
- Pattern generator: one registered bit p, replicated to SHIFT_IN. Reset value 1. MODE latched into mode_q only while EN=0; MODE changes while EN=1 are ignored. When EN=0, p is forced to the mode's idle value (1 for modes 0/2/3, 0 for mode 1). When EN=1: mode 0 holds 1, mode 1 holds 0, mode 2 toggles every cycle, starting from the idle value.
- Expected path: p feeds a delay line of depth D = LAT + SYNC_STAGES. Its output exp is compared bitwise with the synchronized SHIFT_OUT.
- Blanking: counter blk loads D on reset, on EN rising, and while EN=0. It decrements to 0 while EN=1. Compare is enabled only when EN=1 and blk=0.
- Mismatch: registered per-channel flag m = compare_en & (sync_out != exp). One error event is counted per rising edge of m (m & !m_prev). A multi-cycle error run counts once.
- Counters: on an event, counter +1. When the counter is at all-ones, it holds and sets the sticky OVF flag. CLR zeroes all counters, OVF flags, m and m_prev; CLR wins over a simultaneous event.
- Readout: RD_DATA/RD_OVF = counter/flag[RD_SEL], registered. An out-of-range RD_SEL returns 0.
- ANY_ERR: registered OR-reduce of counters != 0.
- Reset values: SHIFT_IN all-ones, counters 0, OVF 0, RD_DATA 0, RD_OVF 0, ANY_ERR 0, m/m_prev 0, delay line all-ones, mode_q 0.

## Timing
- SHIFT_IN changes on the CLK edge after p updates. A chain output transition sampled at edge k reaches m at edge k+SYNC_STAGES. The counter increments at edge k+SYNC_STAGES+1.
- RD_DATA latency: 1 cycle from RD_SEL or counter change. ANY_ERR also lags the counter by 1 cycle.
- First compare occurs D cycles after EN rises.
- EN falling mid-event: compare disables at once. m clears on the next edge, and no event is generated.
- RST asserted mid-run clears all state asynchronously. On release, the block restarts in the blanked state.
- SET pulses shorter than one CLK period may be missed. This is accepted; the monitor is synchronous by design.

## Test plan
Bench parameters: NUM_CH=2, CNT_W=4, LAT=3, SYNC_STAGES=2, so D=5. The DUT is modelled as a 3-cycle delay of SHIFT_IN.
- Reset/idle: RST pulse -> SHIFT_IN=2'b11, RD_DATA=0, RD_OVF=0, ANY_ERR=0. 200 clean cycles in mode 0 with EN=1 -> both counts stay 0.
- Mode 0 error run: force ch0 output low for 5 cycles -> RD_SEL=0 reads 1, RD_SEL=1 reads 0, and ANY_ERR goes to 1. Then three separate 1-cycle low pulses on ch0 -> count0 reads 4.
- Mode 2 alternating: flip one bit of the ch1 stream for 1 cycle -> count1=1 and count0=0. Mode 1 with ch0 stuck at 1 -> count0=1, not one count per cycle.
- Saturation: 20 isolated error pulses on ch1 -> count1=15, RD_OVF=1. CLR -> count1=0, RD_OVF=0. CLR asserted in the same cycle as an event -> count stays 0.
- Blanking: after EN rises, inject mismatches in cycles 0–4 -> no count. A mismatch in cycle 5 -> count=1. A MODE change while EN=1 -> pattern unchanged.
- RST mid-run: with count0=7, assert RST for 1 cycle -> all counts 0 immediately. After release, a mismatch within D cycles of EN high is ignored.
